// File: rtl/ctrl_multiciclo_hs_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package ctrl_multiciclo_hs_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_WB_ALU = 4'd5,
    ST_ADDR   = 4'd6,
    ST_MEM_RD = 4'd7,
    ST_MEM_WR = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_BRANCH = 4'd10,
    ST_LUI    = 4'd11,
    ST_JAL    = 4'd12,
    ST_JALR   = 4'd13,
    ST_TRAP   = 4'd14
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic       SEL_ADDR_PC     = 1'b0;
  localparam logic       SEL_ADDR_ALUOUT = 1'b1;
  localparam logic [1:0] SEL_PC_ALU      = 2'd0;
  localparam logic [1:0] SEL_PC_ALUOUT   = 2'd1;
  localparam logic [1:0] SEL_PC_TRAP     = 2'd2;
  localparam logic       SEL_A_PC        = 1'b0;
  localparam logic       SEL_A_REG       = 1'b1;
  localparam logic [1:0] SEL_B_REG       = 2'd0;
  localparam logic [1:0] SEL_B_FOUR      = 2'd1;
  localparam logic [1:0] SEL_B_IMM       = 2'd2;
  localparam logic [1:0] SEL_B_IMM_SH1   = 2'd3;
  localparam logic [1:0] SEL_WB_ALUOUT   = 2'd0;
  localparam logic [1:0] SEL_WB_MDR      = 2'd1;
  localparam logic [1:0] SEL_WB_IMM      = 2'd2;
  localparam logic [1:0] SEL_WB_PC       = 2'd3;

  // States that hold mem_req and wait for mem_ready.
  function automatic logic isWaitState(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_multiciclo_hs_mem_wait_timer.sv
// Counts stalled cycles of one memory access and flags the last allowed one.
module ctrl_multiciclo_hs_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] countR;

  // Wait counter: cleared on entry to a wait state, saturating increment while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      countR <= '0;
    end else if (clear) begin
      countR <= '0;
    end else if (inc && (countR != CNT_MAX)) begin
      countR <= countR + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      countR <= countR;
    end
  end

  // A zero timeout disables the trap entirely.
  assign expired = (MEM_TIMEOUT != 0) && (countR == LAST_WAIT);

endmodule

// File: rtl/ctrl_multiciclo_hs.sv
// Multicycle RV32I control FSM with memory handshake, timeout and trap support.
module ctrl_multiciclo_hs
  import ctrl_multiciclo_hs_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  input  logic               alu_lt,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               sel_mem_addr,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         sel_pc,
  output logic               ir_load,
  output logic               a_load,
  output logic               b_load,
  output logic               aluout_load,
  output logic               mdr_load,
  output logic               reg_write,
  output logic               epc_load,
  output logic               sel_alu_a,
  output logic [1:0]         sel_alu_b,
  output logic [1:0]         sel_wb,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         cause
);

  state_t      stateR, nextStateS;
  logic [1:0]  causeR, trapCauseS;
  logic        timerExpiredS, timerClearS, timerIncS;
  logic [6:0]  opcodeS, funct7S;
  logic [2:0]  funct3S;
  logic        unusedInstrS;

  assign opcodeS      = instr[6:0];
  assign funct3S      = instr[14:12];
  assign funct7S      = instr[31:25];
  assign unusedInstrS = ^{instr[24:15], instr[11:7]};

  assign timerIncS   = isWaitState(stateR) && !mem_ready;
  assign timerClearS = isWaitState(nextStateS) && (nextStateS != stateR);

  ctrl_multiciclo_hs_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timerClearS),
    .inc    (timerIncS),
    .expired(timerExpiredS)
  );

  // State register and latched trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR <= ST_RESET;
      causeR <= CAUSE_NONE;
    end else begin
      stateR <= nextStateS;
      if (nextStateS == ST_TRAP) begin
        causeR <= trapCauseS;
      end else begin
        causeR <= causeR;
      end
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    nextStateS    = ST_RESET;
    trapCauseS    = CAUSE_NONE;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    sel_mem_addr  = SEL_ADDR_PC;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    sel_pc        = SEL_PC_ALU;
    ir_load       = 1'b0;
    a_load        = 1'b0;
    b_load        = 1'b0;
    aluout_load   = 1'b0;
    mdr_load      = 1'b0;
    reg_write     = 1'b0;
    epc_load      = 1'b0;
    sel_alu_a     = SEL_A_PC;
    sel_alu_b     = SEL_B_REG;
    sel_wb        = SEL_WB_ALUOUT;
    alu_op        = ALUOP_W'(ALU_PASS);
    cause         = CAUSE_NONE;
    case (stateR)
      ST_RESET: nextStateS = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          sel_alu_b  = SEL_B_FOUR;
          alu_op     = ALUOP_W'(ALU_ADD);
          nextStateS = ST_DECODE;
        end else if (timerExpiredS) begin
          trapCauseS = CAUSE_TIMEOUT;
          nextStateS = ST_TRAP;
        end else begin
          nextStateS = ST_FETCH;
        end
      end
      ST_DECODE: begin
        a_load      = 1'b1;
        b_load      = 1'b1;
        aluout_load = 1'b1;
        sel_alu_b   = SEL_B_IMM_SH1;
        alu_op      = ALUOP_W'(ALU_ADD);
        trapCauseS  = CAUSE_ILLEGAL;
        case (opcodeS)
          OP_RTYPE: begin
            if ((funct7S == F7_ADD) || (funct7S == F7_SUB)) begin
              nextStateS = ST_EXEC_R;
            end else begin
              nextStateS = ST_TRAP;
            end
          end
          OP_ITYPE:  nextStateS = ST_EXEC_I;
          OP_LOAD:   nextStateS = ST_ADDR;
          OP_STORE:  nextStateS = ST_ADDR;
          OP_BRANCH: nextStateS = ST_BRANCH;
          OP_LUI:    nextStateS = ST_LUI;
          OP_JAL:    nextStateS = ST_JAL;
          OP_JALR:   nextStateS = ST_JALR;
          default:   nextStateS = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        sel_alu_a   = SEL_A_REG;
        sel_alu_b   = SEL_B_REG;
        aluout_load = 1'b1;
        alu_op      = (funct7S == F7_SUB) ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
        nextStateS  = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        sel_alu_a   = SEL_A_REG;
        sel_alu_b   = SEL_B_IMM;
        aluout_load = 1'b1;
        alu_op      = ALUOP_W'(ALU_ADD);
        nextStateS  = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write  = 1'b1;
        sel_wb     = SEL_WB_ALUOUT;
        nextStateS = ST_FETCH;
      end
      ST_ADDR: begin
        sel_alu_a   = SEL_A_REG;
        sel_alu_b   = SEL_B_IMM;
        aluout_load = 1'b1;
        alu_op      = ALUOP_W'(ALU_ADD);
        nextStateS  = (opcodeS == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req      = 1'b1;
        sel_mem_addr = SEL_ADDR_ALUOUT;
        if (mem_ready) begin
          mdr_load   = 1'b1;
          nextStateS = ST_WB_MEM;
        end else if (timerExpiredS) begin
          trapCauseS = CAUSE_TIMEOUT;
          nextStateS = ST_TRAP;
        end else begin
          nextStateS = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        sel_mem_addr = SEL_ADDR_ALUOUT;
        if (mem_ready) begin
          nextStateS = ST_FETCH;
        end else if (timerExpiredS) begin
          trapCauseS = CAUSE_TIMEOUT;
          nextStateS = ST_TRAP;
        end else begin
          nextStateS = ST_MEM_WR;
        end
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        sel_wb     = SEL_WB_MDR;
        nextStateS = ST_FETCH;
      end
      ST_BRANCH: begin
        sel_alu_a  = SEL_A_REG;
        sel_alu_b  = SEL_B_REG;
        sel_pc     = SEL_PC_ALUOUT;
        alu_op     = funct3S[2] ? ALUOP_W'(ALU_SLT) : ALUOP_W'(ALU_SUB);
        nextStateS = ST_FETCH;
        case (funct3S)
          F3_BEQ: pc_write_cond = alu_zero;
          F3_BNE: pc_write_cond = !alu_zero;
          F3_BLT: pc_write_cond = alu_lt;
          F3_BGE: pc_write_cond = !alu_lt;
          default: begin
            trapCauseS = CAUSE_ILLEGAL;
            nextStateS = ST_TRAP;
          end
        endcase
      end
      ST_LUI: begin
        reg_write  = 1'b1;
        sel_wb     = SEL_WB_IMM;
        nextStateS = ST_FETCH;
      end
      ST_JAL: begin
        reg_write  = 1'b1;
        sel_wb     = SEL_WB_PC;
        pc_write   = 1'b1;
        sel_pc     = SEL_PC_ALUOUT;
        nextStateS = ST_FETCH;
      end
      ST_JALR: begin
        sel_alu_a  = SEL_A_REG;
        sel_alu_b  = SEL_B_IMM;
        alu_op     = ALUOP_W'(ALU_ADD);
        pc_write   = 1'b1;
        sel_pc     = SEL_PC_ALU;
        reg_write  = 1'b1;
        sel_wb     = SEL_WB_PC;
        nextStateS = ST_FETCH;
      end
      ST_TRAP: begin
        epc_load   = 1'b1;
        cause      = causeR;
        pc_write   = 1'b1;
        sel_pc     = SEL_PC_TRAP;
        nextStateS = ST_FETCH;
      end
      default: nextStateS = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_ctrl_multiciclo_hs.sv
// Directed self-checking bench for the multicycle control FSM.
module tb_ctrl_multiciclo_hs;

  logic        clk, rst, alu_zero, alu_lt, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, sel_mem_addr, pc_write, pc_write_cond;
  logic [1:0]  sel_pc, sel_alu_b, sel_wb, cause;
  logic        ir_load, a_load, b_load, aluout_load, mdr_load, reg_write, epc_load, sel_alu_a;
  logic [2:0]  alu_op;
  logic [23:0] outVec;

  int testsRun = 0;
  int testsFailed = 0;

  logic [23:0] oFetchWait, oFetchRdy, oDecode, oExecAdd, oExecSub, oExecI, oWbAlu, oAddr;
  logic [23:0] oMemRdRdy, oWbMem, oMemWr, oLui, oJal, oJalr, oTrap1, oTrap2;

  ctrl_multiciclo_hs #(.ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .sel_mem_addr(sel_mem_addr),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .sel_pc(sel_pc), .ir_load(ir_load),
    .a_load(a_load), .b_load(b_load), .aluout_load(aluout_load), .mdr_load(mdr_load),
    .reg_write(reg_write), .epc_load(epc_load), .sel_alu_a(sel_alu_a), .sel_alu_b(sel_alu_b),
    .sel_wb(sel_wb), .alu_op(alu_op), .cause(cause)
  );

  assign outVec = {mem_req, mem_we, sel_mem_addr, pc_write, pc_write_cond, sel_pc,
                   ir_load, a_load, b_load, aluout_load, mdr_load, reg_write, epc_load,
                   sel_alu_a, sel_alu_b, sel_wb, alu_op, cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: req we addr pcw pcwc selpc | ir a b aluo mdr rw epc sela | selb selwb aluop cause
  function automatic logic [23:0] mk(input logic rq, we, ad, pw, pc, input logic [1:0] sp,
                                     input logic ir, a, b, ao, md, rw, ep, sa,
                                     input logic [1:0] sb, sw, input logic [2:0] op,
                                     input logic [1:0] ca);
    return {rq, we, ad, pw, pc, sp, ir, a, b, ao, md, rw, ep, sa, sb, sw, op, ca};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; instr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if (outVec !== 24'h0) begin
        testsFailed++;
        $display("FAIL reset_outputs cyc%0d: got %h expected %h", i, outVec, 24'h0);
      end
    end
    rst = 1'b0; mem_ready = 1'b0; #1;
    testsRun++;
    if (outVec !== 24'h0) begin
      testsFailed++;
      $display("FAIL reset_release_same_cycle: got %h expected %h", outVec, 24'h0);
    end
    tick();
    testsRun++;
    if (outVec !== oFetchWait) begin
      testsFailed++;
      $display("FAIL reset_first_fetch: got %h expected %h", outVec, oFetchWait);
    end
  endtask

  task automatic test_add();
    logic [23:0] exp [4];
    int rwCount;
    exp = '{oDecode, oExecAdd, oWbAlu, oFetchWait};
    doReset();
    instr = 32'h002081B3;
    rwCount = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4); #1;
      rwCount += int'(reg_write);
      testsRun++;
      if (outVec !== ((i == 4) ? oFetchRdy : oFetchWait)) begin
        testsFailed++;
        $display("FAIL add_fetch cyc%0d: got %h expected %h", i, outVec,
                 (i == 4) ? oFetchRdy : oFetchWait);
      end
      tick();
    end
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      rwCount += int'(reg_write);
      testsRun++;
      if (outVec !== exp[i]) begin
        testsFailed++;
        $display("FAIL add_step%0d: got %h expected %h", i, outVec, exp[i]);
      end
      tick();
    end
    testsRun++;
    if (rwCount !== 1) begin
      testsFailed++;
      $display("FAIL add_reg_write_count: got %0d expected 1", rwCount);
    end
  endtask

  task automatic test_alu_variants();
    logic [31:0] ins [3];
    logic [23:0] exp [3][3];
    ins = '{32'h402081B3, 32'h00108093, 32'h022081B3};
    exp = '{'{oDecode, oExecSub, oWbAlu}, '{oDecode, oExecI, oWbAlu}, '{oDecode, oTrap1, oFetchWait}};
    for (int t = 0; t < 3; t++) begin
      doReset();
      instr = ins[t]; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
        testsRun++;
        if (outVec !== exp[t][i]) begin
          testsFailed++;
          $display("FAIL alu_variant%0d step%0d: got %h expected %h", t, i, outVec, exp[t][i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_lw();
    logic [23:0] exp [6];
    exp = '{oFetchRdy, oDecode, oAddr, oMemRdRdy, oWbMem, oFetchWait};
    doReset();
    instr = 32'h0080A283; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_ready = 1'b0;
      #1;
      testsRun++;
      if (outVec !== exp[i]) begin
        testsFailed++;
        $display("FAIL lw_step%0d: got %h expected %h", i, outVec, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [5];
    logic       zr [5];
    logic       lt [5];
    logic       tk [5];
    f3 = '{3'd1, 3'd5, 3'd0, 3'd4, 3'd0};
    zr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    lt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tk = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 5; t++) begin
      logic [23:0] e;
      e = mk(0,0,0,0,tk[t],2'd1, 0,0,0,0,0,0,0,1, 2'd0,2'd0, f3[t][2] ? 3'd3 : 3'd2, 2'd0);
      doReset();
      instr = {17'd0, f3[t], 5'd0, 7'b1100011}; mem_ready = 1'b1;
      tick(); tick();
      alu_zero = zr[t]; alu_lt = lt[t]; mem_ready = 1'b0; #1;
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL branch_f3_%0d z%0d lt%0d: got %h expected %h", f3[t], zr[t], lt[t], outVec, e);
      end
      tick();
      testsRun++;
      if (outVec !== oFetchWait) begin
        testsFailed++;
        $display("FAIL branch_return_%0d: got %h expected %h", t, outVec, oFetchWait);
      end
    end
    doReset();
    instr = {17'd0, 3'd2, 5'd0, 7'b1100011}; mem_ready = 1'b1;
    tick(); tick(); tick();
    testsRun++;
    if (outVec !== oTrap1) begin
      testsFailed++;
      $display("FAIL branch_bad_funct3_trap: got %h expected %h", outVec, oTrap1);
    end
  endtask

  task automatic test_upper();
    logic [31:0] ins [3];
    logic [23:0] ex [3];
    ins = '{32'h000012B7, 32'h008000EF, 32'h00008067};
    ex = '{oLui, oJal, oJalr};
    for (int t = 0; t < 3; t++) begin
      doReset();
      instr = ins[t]; mem_ready = 1'b1;
      tick(); tick();
      mem_ready = 1'b0; #1;
      testsRun++;
      if (outVec !== ex[t]) begin
        testsFailed++;
        $display("FAIL upper%0d: got %h expected %h", t, outVec, ex[t]);
      end
      tick();
      testsRun++;
      if (outVec !== oFetchWait) begin
        testsFailed++;
        $display("FAIL upper%0d_return: got %h expected %h", t, outVec, oFetchWait);
      end
    end
  endtask

  task automatic test_illegal();
    doReset();
    instr = 32'h0; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0; #1;
    testsRun++;
    if (outVec !== oTrap1) begin
      testsFailed++;
      $display("FAIL illegal_opcode_trap: got %h expected %h", outVec, oTrap1);
    end
    tick();
    testsRun++;
    if (outVec !== oFetchWait) begin
      testsFailed++;
      $display("FAIL illegal_return_fetch: got %h expected %h", outVec, oFetchWait);
    end
  endtask

  // Brings a SW to its first MEM_WR cycle.
  task automatic toStore();
    doReset();
    instr = 32'h0020A423; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
  endtask

  task automatic test_timeout();
    int badWaits;
    toStore();
    badWaits = 0;
    for (int i = 0; i < 15; i++) begin
      if (outVec !== oMemWr) badWaits++;
      tick();
    end
    testsRun++;
    if (badWaits !== 0) begin
      testsFailed++;
      $display("FAIL store_wait_cycles: got %0d bad cycles expected 0", badWaits);
    end
    testsRun++;
    if (outVec !== oTrap2) begin
      testsFailed++;
      $display("FAIL store_timeout_trap: got %h expected %h", outVec, oTrap2);
    end
    doReset();
    for (int i = 0; i < 15; i++) tick();
    testsRun++;
    if (outVec !== oTrap2) begin
      testsFailed++;
      $display("FAIL fetch_timeout_trap: got %h expected %h", outVec, oTrap2);
    end
  endtask

  task automatic test_late_ready();
    toStore();
    for (int i = 0; i < 14; i++) tick();
    mem_ready = 1'b1; #1;
    testsRun++;
    if (outVec !== oMemWr) begin
      testsFailed++;
      $display("FAIL late_ready_15th: got %h expected %h", outVec, oMemWr);
    end
    tick();
    mem_ready = 1'b0; #1;
    testsRun++;
    if (outVec !== oFetchWait) begin
      testsFailed++;
      $display("FAIL late_ready_no_trap: got %h expected %h", outVec, oFetchWait);
    end
  endtask

  task automatic test_rst_mid_access();
    toStore();
    tick(); tick();
    rst = 1'b1;
    tick();
    testsRun++;
    if (outVec !== 24'h0) begin
      testsFailed++;
      $display("FAIL rst_mid_store: got %h expected %h", outVec, 24'h0);
    end
    rst = 1'b0;
    tick();
    testsRun++;
    if (outVec !== oFetchWait) begin
      testsFailed++;
      $display("FAIL rst_mid_store_refetch: got %h expected %h", outVec, oFetchWait);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    oFetchWait = mk(1,0,0,0,0,2'd0, 0,0,0,0,0,0,0,0, 2'd0,2'd0,3'd0,2'd0);
    oFetchRdy  = mk(1,0,0,1,0,2'd0, 1,0,0,0,0,0,0,0, 2'd1,2'd0,3'd1,2'd0);
    oDecode    = mk(0,0,0,0,0,2'd0, 0,1,1,1,0,0,0,0, 2'd3,2'd0,3'd1,2'd0);
    oExecAdd   = mk(0,0,0,0,0,2'd0, 0,0,0,1,0,0,0,1, 2'd0,2'd0,3'd1,2'd0);
    oExecSub   = mk(0,0,0,0,0,2'd0, 0,0,0,1,0,0,0,1, 2'd0,2'd0,3'd2,2'd0);
    oExecI     = mk(0,0,0,0,0,2'd0, 0,0,0,1,0,0,0,1, 2'd2,2'd0,3'd1,2'd0);
    oWbAlu     = mk(0,0,0,0,0,2'd0, 0,0,0,0,0,1,0,0, 2'd0,2'd0,3'd0,2'd0);
    oAddr      = mk(0,0,0,0,0,2'd0, 0,0,0,1,0,0,0,1, 2'd2,2'd0,3'd1,2'd0);
    oMemRdRdy  = mk(1,0,1,0,0,2'd0, 0,0,0,0,1,0,0,0, 2'd0,2'd0,3'd0,2'd0);
    oWbMem     = mk(0,0,0,0,0,2'd0, 0,0,0,0,0,1,0,0, 2'd0,2'd1,3'd0,2'd0);
    oMemWr     = mk(1,1,1,0,0,2'd0, 0,0,0,0,0,0,0,0, 2'd0,2'd0,3'd0,2'd0);
    oLui       = mk(0,0,0,0,0,2'd0, 0,0,0,0,0,1,0,0, 2'd0,2'd2,3'd0,2'd0);
    oJal       = mk(0,0,0,1,0,2'd1, 0,0,0,0,0,1,0,0, 2'd0,2'd3,3'd0,2'd0);
    oJalr      = mk(0,0,0,1,0,2'd0, 0,0,0,0,0,1,0,1, 2'd2,2'd3,3'd1,2'd0);
    oTrap1     = mk(0,0,0,1,0,2'd2, 0,0,0,0,0,0,1,0, 2'd0,2'd0,3'd0,2'd1);
    oTrap2     = mk(0,0,0,1,0,2'd2, 0,0,0,0,0,0,1,0, 2'd0,2'd0,3'd0,2'd2);
    rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0; instr = 32'h0;

    test_reset();
    test_add();
    test_alu_variants();
    test_lw();
    test_branch();
    test_upper();
    test_illegal();
    test_timeout();
    test_late_ready();
    test_rst_mid_access();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
